vm_dispense_ctrl: RTL and testbench
===================================

VM_DISPENSE_CTRL -- requirements
Module: vm_dispense_ctrl

Interface
REQ-001 Parameters SHALL be: STOCK_INIT, default 8, per-drink load value (4-bit); COIN_INIT, default 15, Rs5 coin load value (5-bit); MOTOR_CYCLES, default 4, motor-on duration; COIN_TIMEOUT, default 16, max cycles to wait for coin_sensed.
REQ-002 There SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 y  input  2  dispense code, single-cycle pulse (01 CocaCola, 10 Pepsi, 00/11 none).
REQ-006 c  input  2  change code, single-cycle pulse (00 Rs0, 01 Rs5, 10 Rs10, 11 treated as Rs0).
REQ-007 coin_sensed  input  1  hopper acknowledges one coin ejected.
REQ-008 restock  input  1  reload both drink stock counters.
REQ-009 clr_flags  input  1  clear sticky overrun/short_change.
REQ-010 motor_coke, motor_pepsi  output  1 each  drink motor drives.
REQ-011 coin_eject  output  1  request one Rs5 coin from hopper.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 empty_coke, empty_pepsi  output  1 each  stock counter equals 0.
REQ-014 overrun, short_change, fault  output  1 each  sticky status flags.

Function
REQ-015 A request SHALL be accepted only in IDLE on a cycle where y is 01/10 or c is 01/10; y and c SHALL be captured together on that cycle.
REQ-016 States SHALL be IDLE, VEND, COIN_REQ, COIN_GAP, FAULT.
REQ-017 IDLE -> VEND when captured drink is valid and its stock > 0; else IDLE -> COIN_REQ when coins owed > 0; else remain IDLE.
REQ-018 VEND SHALL assert the selected motor for exactly MOTOR_CYCLES cycles starting the cycle after acceptance, decrement that stock by 1 on exit, then go to COIN_REQ if coins owed > 0, else IDLE.
REQ-019 A valid drink request with stock 0 SHALL drive no motor and proceed directly to change handling.
REQ-020 Coins owed SHALL be 1 for c=01 and 2 for c=10.
REQ-021 COIN_REQ SHALL hold coin_eject high until coin_sensed; on coin_sensed: decrement coin count and coins owed, deassert coin_eject next cycle, enter COIN_GAP.
REQ-022 COIN_GAP SHALL last one cycle, then COIN_REQ if coins owed > 0, else IDLE.
REQ-023 If coin count is 0 on entry to COIN_REQ, short_change SHALL set, coins owed SHALL clear, and FSM SHALL return to IDLE without asserting coin_eject.
REQ-024 If coin_sensed does not arrive within COIN_TIMEOUT cycles of coin_eject rising, FSM SHALL enter FAULT, deassert coin_eject, set fault; FAULT SHALL exit only on reset.
REQ-025 coin_sensed outside COIN_REQ SHALL be ignored.
REQ-026 A request (y or c non-zero) arriving while busy SHALL be dropped and set overrun.
REQ-027 restock SHALL reload both stocks to STOCK_INIT only in IDLE with no request that cycle; otherwise it is ignored.
REQ-028 clr_flags SHALL clear overrun and short_change; a same-cycle set SHALL win; fault is unaffected.
REQ-029 Stock and coin counters SHALL saturate at 0.
REQ-030 Motor and coin_eject outputs SHALL be registered and mutually exclusive.

Reset
REQ-031 On reset low: state IDLE, all outputs 0 except empty_* (0 with STOCK_INIT>0), stocks = STOCK_INIT, coins = COIN_INIT, captured request and coins owed cleared.
REQ-032 Reset mid-VEND or mid-COIN_REQ SHALL drop motor/coin_eject immediately (asynchronously) and discard the pending request.

Structure
REQ-033 Shared package vm_pkg SHALL hold the state enum, drink codes (01/10) and change codes (00/01/10).
REQ-034 One sub-module vm_down_counter (load, enable, zero flag) SHALL implement the motor and timeout timers.

Verification
REQ-035 y=01, c=00 pulse -> motor_coke high 4 cycles, stock_coke 8->7, busy low after.
REQ-036 y=10, c=10, hopper acks after 3 cycles each -> motor_pepsi 4 cycles, then two coin_eject pulses separated by COIN_GAP, coins 15->13.
REQ-037 Drain coke to 0 (8 vends), then y=01, c=01 -> empty_coke=1, no motor, one coin ejected.
REQ-038 c=01 with coin_sensed never asserted -> fault=1 after 16 cycles, coin_eject=0, busy held until reset.
REQ-039 Second y=01 pulse during VEND -> overrun=1, ignored; clr_flags -> overrun=0.
REQ-040 Reset low during VEND cycle 2 -> motor_coke=0 same cycle, stock=8, state IDLE after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and codes for the vending machine dispense controller.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND,
        ST_COIN_REQ,
        ST_COIN_GAP,
        ST_FAULT
    } vm_state_t;

    localparam logic [1:0] DRINK_NONE  = 2'b00;
    localparam logic [1:0] DRINK_COKE  = 2'b01;
    localparam logic [1:0] DRINK_PEPSI = 2'b10;

    localparam logic [1:0] CHG_RS0  = 2'b00;
    localparam logic [1:0] CHG_RS5  = 2'b01;
    localparam logic [1:0] CHG_RS10 = 2'b10;

    localparam int unsigned OWED_W = 2;

    // Request captured on acceptance: selected drink and Rs5 coins still owed.
    typedef struct packed {
        logic [1:0]        drink;
        logic [OWED_W-1:0] owed;
    } vm_req_t;

    function automatic logic [OWED_W-1:0] coins_owed(input logic [1:0] chg);
        case (chg)
            CHG_RS0:  return OWED_W'(0);
            CHG_RS5:  return OWED_W'(1);
            CHG_RS10: return OWED_W'(2);
            default:  return OWED_W'(0);
        endcase
    endfunction

    function automatic logic is_drink(input logic [1:0] code);
        return (code == DRINK_COKE) || (code == DRINK_PEPSI);
    endfunction

endpackage

// File: rtl/vm_down_counter.sv
// Loadable down counter that stops at zero; used for motor and hopper timeouts.
module vm_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/vm_dispense_ctrl.sv
// Drink dispense and Rs5 change controller: accepts a drink/change request in IDLE,
// runs the selected motor, then pays change one hopper coin at a time.
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter logic [3:0]  STOCK_INIT   = 4'd8,
    parameter logic [4:0]  COIN_INIT    = 5'd15,
    parameter int unsigned MOTOR_CYCLES = 4,
    parameter int unsigned COIN_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] y,
    input  logic [1:0] c,
    input  logic       coin_sensed,
    input  logic       restock,
    input  logic       clr_flags,
    output logic       motor_coke,
    output logic       motor_pepsi,
    output logic       coin_eject,
    output logic       busy,
    output logic       empty_coke,
    output logic       empty_pepsi,
    output logic       overrun,
    output logic       short_change,
    output logic       fault
);

    localparam int unsigned STOCK_W = 4;
    localparam int unsigned COIN_W  = 5;
    localparam int unsigned MTR_W   = $clog2(MOTOR_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(COIN_TIMEOUT + 1);
    localparam logic [MTR_W-1:0] MTR_LOAD = MTR_W'(MOTOR_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(COIN_TIMEOUT - 1);

    vm_state_t          state, state_n;
    vm_req_t            req_q, req_n;
    logic [STOCK_W-1:0] stock_coke_q, stock_coke_n;
    logic [STOCK_W-1:0] stock_pepsi_q, stock_pepsi_n;
    logic [COIN_W-1:0]  coins_q, coins_n;
    logic motor_coke_n, motor_pepsi_n, coin_eject_n, fault_n;
    logic overrun_set, short_set;
    logic mtr_load, mtr_en, mtr_zero, to_load, to_en, to_zero;

    logic req_any_c, req_valid_c, drink_ok_c;

    assign req_any_c   = (y != 2'b00) || (c != 2'b00);
    assign req_valid_c = is_drink(y) || (c == CHG_RS5) || (c == CHG_RS10);
    assign drink_ok_c  = ((y == DRINK_COKE)  && (stock_coke_q  != '0)) ||
                         ((y == DRINK_PEPSI) && (stock_pepsi_q != '0));

    vm_down_counter #(.WIDTH(MTR_W)) u_motor_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (mtr_load),
        .en       (mtr_en),
        .load_val (MTR_LOAD),
        .zero_c   (mtr_zero)
    );

    vm_down_counter #(.WIDTH(TO_W)) u_coin_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load),
        .en       (to_en),
        .load_val (TO_LOAD),
        .zero_c   (to_zero)
    );

    // Next-state, counter and output decode; outputs are registered from *_n below.
    always_comb begin
        state_n       = state;
        req_n         = req_q;
        stock_coke_n  = stock_coke_q;
        stock_pepsi_n = stock_pepsi_q;
        coins_n       = coins_q;
        motor_coke_n  = 1'b0;
        motor_pepsi_n = 1'b0;
        coin_eject_n  = 1'b0;
        fault_n       = fault;
        overrun_set   = 1'b0;
        short_set     = 1'b0;
        mtr_load      = 1'b0;
        mtr_en        = 1'b0;
        to_load       = 1'b0;
        to_en         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid_c) begin
                    req_n.drink = is_drink(y) ? y : DRINK_NONE;
                    req_n.owed  = coins_owed(c);
                    if (drink_ok_c) begin
                        state_n       = ST_VEND;
                        motor_coke_n  = (y == DRINK_COKE);
                        motor_pepsi_n = (y == DRINK_PEPSI);
                        mtr_load      = 1'b1;
                    end else if (coins_owed(c) != '0) begin
                        state_n      = ST_COIN_REQ;
                        coin_eject_n = (coins_q != '0);
                        to_load      = 1'b1;
                    end else begin
                        req_n = '0;
                    end
                end else if (restock && !req_any_c) begin
                    stock_coke_n  = STOCK_INIT;
                    stock_pepsi_n = STOCK_INIT;
                end
            end
            ST_VEND: begin
                if (mtr_zero) begin
                    if ((req_q.drink == DRINK_COKE) && (stock_coke_q != '0))
                        stock_coke_n = stock_coke_q - STOCK_W'(1);
                    if ((req_q.drink == DRINK_PEPSI) && (stock_pepsi_q != '0))
                        stock_pepsi_n = stock_pepsi_q - STOCK_W'(1);
                    if (req_q.owed != '0) begin
                        state_n      = ST_COIN_REQ;
                        coin_eject_n = (coins_q != '0);
                        to_load      = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        req_n   = '0;
                    end
                end else begin
                    motor_coke_n  = (req_q.drink == DRINK_COKE);
                    motor_pepsi_n = (req_q.drink == DRINK_PEPSI);
                    mtr_en        = 1'b1;
                end
            end
            ST_COIN_REQ: begin
                // An empty hopper is flagged on entry; eject was never raised.
                if (coins_q == '0) begin
                    short_set = 1'b1;
                    req_n     = '0;
                    state_n   = ST_IDLE;
                end else if (coin_sensed) begin
                    coins_n = coins_q - COIN_W'(1);
                    if (req_q.owed != '0)
                        req_n.owed = req_q.owed - OWED_W'(1);
                    state_n = ST_COIN_GAP;
                end else if (to_zero) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                end else begin
                    coin_eject_n = 1'b1;
                    to_en        = 1'b1;
                end
            end
            ST_COIN_GAP: begin
                if (req_q.owed != '0) begin
                    state_n      = ST_COIN_REQ;
                    coin_eject_n = (coins_q != '0);
                    to_load      = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    req_n   = '0;
                end
            end
            ST_FAULT: begin
                fault_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if ((state != ST_IDLE) && req_any_c)
            overrun_set = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            stock_coke_q <= STOCK_INIT;
            stock_pepsi_q <= STOCK_INIT;
            coins_q      <= COIN_INIT;
            motor_coke   <= 1'b0;
            motor_pepsi  <= 1'b0;
            coin_eject   <= 1'b0;
            busy         <= 1'b0;
            empty_coke   <= (STOCK_INIT == '0);
            empty_pepsi  <= (STOCK_INIT == '0);
            overrun      <= 1'b0;
            short_change <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            req_q        <= req_n;
            stock_coke_q <= stock_coke_n;
            stock_pepsi_q <= stock_pepsi_n;
            coins_q      <= coins_n;
            motor_coke   <= motor_coke_n;
            motor_pepsi  <= motor_pepsi_n;
            coin_eject   <= coin_eject_n;
            busy         <= (state_n != ST_IDLE);
            empty_coke   <= (stock_coke_n == '0);
            empty_pepsi  <= (stock_pepsi_n == '0);
            overrun      <= overrun_set | (overrun & ~clr_flags);
            short_change <= short_set | (short_change & ~clr_flags);
            fault        <= fault_n;
        end
    end

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Scoreboard bench: each output-vector change is popped against an expected
// (vector, run length) entry queued by the stimulus process.
module tb_vm_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] y = 2'b00;
    logic [1:0] c = 2'b00;
    logic       coin_sensed = 1'b0;
    logic       restock = 1'b0;
    logic       clr_flags = 1'b0;
    logic motor_coke, motor_pepsi, coin_eject, busy;
    logic empty_coke, empty_pepsi, overrun, short_change, fault;

    vm_dispense_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .y            (y),
        .c            (c),
        .coin_sensed  (coin_sensed),
        .restock      (restock),
        .clr_flags    (clr_flags),
        .motor_coke   (motor_coke),
        .motor_pepsi  (motor_pepsi),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .empty_coke   (empty_coke),
        .empty_pepsi  (empty_pepsi),
        .overrun      (overrun),
        .short_change (short_change),
        .fault        (fault)
    );

    initial forever #5 clk = ~clk;

    // Vector bits: {mc, mp, ce, busy, ec, ep, ov, sc, fault}
    localparam logic [8:0] V0 = 9'b000000000;
    localparam logic [8:0] MC = 9'b100000000;
    localparam logic [8:0] MP = 9'b010000000;
    localparam logic [8:0] CE = 9'b001000000;
    localparam logic [8:0] B  = 9'b000100000;
    localparam logic [8:0] EC = 9'b000010000;
    localparam logic [8:0] OV = 9'b000000100;
    localparam logic [8:0] SC = 9'b000000010;
    localparam logic [8:0] F  = 9'b000000001;

    int checks = 0;
    int failures = 0;
    int hop_delay = 3;
    int hop_cnt = 0;

    logic [8:0] q_v[$];
    int         q_len[$];
    string      q_name[$];

    task automatic expect_v(input logic [8:0] v, input int len, input string name);
        q_v.push_back(v);
        q_len.push_back(len);
        q_name.push_back(name);
    endtask

    task automatic pulse(input logic [1:0] yy, input logic [1:0] cc, input logic rs, input logic clr);
        @(posedge clk); #1;
        y = yy; c = cc; restock = rs; clr_flags = clr;
        @(posedge clk); #1;
        y = 2'b00; c = 2'b00; restock = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic vend_coke(input logic [8:0] after, input string name);
        expect_v(MC | B, 4, name);
        expect_v(after, 0, {name, " done"});
        pulse(2'b01, 2'b00, 1'b0, 1'b0);
        wait_idle(name);
    endtask

    // Hopper model: acknowledges after hop_delay cycles of coin_eject (0 = never).
    initial forever begin
        @(negedge clk);
        if (coin_eject && hop_delay != 0) begin
            hop_cnt++;
            coin_sensed = (hop_cnt == hop_delay);
        end else begin
            hop_cnt = 0;
            coin_sensed = 1'b0;
        end
    end

    logic [8:0] obs, last_obs, exp_v;
    int         run_len = 0;
    int         cur_len = 0;
    string      cur_name = "none";
    bit         first = 1'b1;

    initial forever begin
        @(negedge clk);
        obs = {motor_coke, motor_pepsi, coin_eject, busy, empty_coke, empty_pepsi,
               overrun, short_change, fault};
        if (first || obs != last_obs) begin
            if (!first && cur_len != 0) begin
                checks++;
                if (run_len != cur_len) begin
                    failures++;
                    $display("FAIL %s length: held %0d cycles, required %0d", cur_name, run_len, cur_len);
                end
            end
            checks++;
            if (q_v.size() == 0) begin
                failures++;
                $display("FAIL unexpected change: outputs %b, none required", obs);
                cur_len = 0;
                cur_name = "unexpected";
            end else begin
                exp_v    = q_v.pop_front();
                cur_len  = q_len.pop_front();
                cur_name = q_name.pop_front();
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL %s: outputs %b, required %b", cur_name, obs, exp_v);
                end
            end
            run_len  = 1;
            last_obs = obs;
            first    = 1'b0;
        end else begin
            run_len++;
        end
    end

    initial begin
        expect_v(V0, 0, "reset state");
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Plain coke vend, no change.
        vend_coke(V0, "coke vend");

        // Pepsi with Rs10 change: two coins separated by a gap cycle.
        expect_v(MP | B, 4, "pepsi motor");
        expect_v(CE | B, 3, "coin 1 eject");
        expect_v(B, 1, "coin 1 gap");
        expect_v(CE | B, 3, "coin 2 eject");
        expect_v(B, 1, "coin 2 gap");
        expect_v(V0, 0, "pepsi done");
        pulse(2'b10, 2'b10, 1'b0, 1'b0);
        wait_idle("pepsi rs10");

        // Request during VEND is dropped; overrun set wins over same-cycle clear.
        expect_v(MC | B, 2, "ovr vend early");
        expect_v(MC | B | OV, 2, "ovr vend late");
        expect_v(OV, 0, "ovr held idle");
        pulse(2'b01, 2'b00, 1'b0, 1'b0);
        pulse(2'b01, 2'b00, 1'b0, 1'b1);
        wait_idle("overrun vend");
        expect_v(V0, 0, "ovr cleared");
        pulse(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (3) @(posedge clk);

        // Coke stock is 6 here; drain it, then an empty-stock request pays change only.
        for (int i = 0; i < 5; i++) vend_coke(V0, "coke drain");
        vend_coke(EC, "coke last");
        expect_v(CE | B | EC, 3, "empty coke eject");
        expect_v(B | EC, 1, "empty coke gap");
        expect_v(EC, 0, "empty coke done");
        pulse(2'b01, 2'b01, 1'b0, 1'b0);
        wait_idle("empty coke rs5");

        expect_v(V0, 0, "restock");
        pulse(2'b00, 2'b00, 1'b1, 1'b0);
        repeat (3) @(posedge clk);

        // 12 coins left: six Rs10 requests empty the hopper.
        hop_delay = 1;
        for (int i = 0; i < 6; i++) begin
            expect_v(CE | B, 1, "drain eject a");
            expect_v(B, 1, "drain gap a");
            expect_v(CE | B, 1, "drain eject b");
            expect_v(B, 1, "drain gap b");
            expect_v(V0, 0, "drain done");
            pulse(2'b00, 2'b10, 1'b0, 1'b0);
            wait_idle("coin drain");
        end
        expect_v(B, 1, "short busy");
        expect_v(SC, 0, "short change");
        pulse(2'b00, 2'b01, 1'b0, 1'b0);
        wait_idle("short change");
        expect_v(V0, 0, "short cleared");
        pulse(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (3) @(posedge clk);

        // Reset in VEND cycle 2 drops the motor and restores stock to 8.
        hop_delay = 3;
        vend_coke(V0, "coke pre reset");
        expect_v(MC | B, 1, "vend before reset");
        expect_v(V0, 0, "reset mid vend");
        pulse(2'b01, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 7; i++) vend_coke(V0, "post reset drain");
        vend_coke(EC, "post reset last");

        // Hopper never acknowledges: fault after the timeout, held until reset.
        hop_delay = 0;
        expect_v(CE | B | EC, 16, "coin timeout");
        expect_v(B | F | EC, 0, "fault hold");
        pulse(2'b00, 2'b01, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        expect_v(V0, 0, "reset from fault");
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        checks++;
        if (q_v.size() != 0) begin
            failures++;
            $display("FAIL pending events: %0d still queued, required 0 (next %s)", q_v.size(), q_name[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
